// File: rtl/debounce_sync_if.sv
// debounce_sync_if
//   Groups the raw input and the conditioned outputs of debounce_sync.
//   Clock and reset are not part of the bundle; they stay plain ports.
//
//   din        raw asynchronous (bouncy) input, driven by the source side
//   d          debounced level, registered; feeds the downstream DFF D pin
//   rise       one-cycle pulse in the cycle d goes 0->1
//   fall       one-cycle pulse in the cycle d goes 1->0
//   busy       high while a transition is being qualified
//   glitch_cnt saturating count of aborted transitions
//
//   master : the side that drives din and consumes the outputs
//   slave  : the debouncer itself
interface debounce_sync_if;
  logic       din;
  logic       d;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] glitch_cnt;

  modport master (
    output din,
    input  d,
    input  rise,
    input  fall,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  din,
    output d,
    output rise,
    output fall,
    output busy,
    output glitch_cnt
  );
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync
//   Input-conditioning stage in front of a single-bit D flip-flop.
//   The raw input passes through a 2-flop synchronizer and then a
//   counter-based stability filter: a new level must be seen on the
//   synchronized input for STABLE_CYCLES consecutive clocks before the
//   debounced output d follows it. Aborted transitions are counted.
//
// Parameters
//   STABLE_CYCLES  cycles a new level must hold before d changes (2..2**CNT_W)
//   CNT_W          width of the stability counter
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        synchronous, active-high reset (highest priority)
//   bus.din    raw asynchronous input
//   bus.d      debounced level (registered)
//   bus.rise   one-cycle pulse with d 0->1
//   bus.fall   one-cycle pulse with d 1->0
//   bus.busy   registered decode of "next state is a WAIT state"
//   bus.glitch_cnt  aborted-transition count, saturates at 255
//
// Timing (edge k = first edge that samples the new din level):
//   sync1 at k, sync2 at k+1, FSM enters WAIT at k+2, d/pulse at
//   k+2+STABLE_CYCLES.
module debounce_sync #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  debounce_sync_if.slave  bus
);

  // Terminal count. STABLE_CYCLES may equal 2**CNT_W, so the last count
  // value (STABLE_CYCLES-1) always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       GC_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_WAIT_HIGH   = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_WAIT_LOW    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_d;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;
  logic [7:0]       r_glitch_cnt;

  // ---------------------------------------------------------------------
  // Combinational next values
  // ---------------------------------------------------------------------
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_done;
  logic             w_abort;     // WAIT abandoned, input bounced back
  logic             w_commit_hi; // WAIT_HIGH qualified
  logic             w_commit_lo; // WAIT_LOW qualified

  logic             w_d_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_busy_nxt;
  logic [7:0]       w_glitch_nxt;

  assign w_cnt_done = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------
  // Synchronizer: only r_sync2 is allowed into the FSM, r_sync1 may be
  // metastable.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.din;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_STABLE_LOW;
      r_cnt        <= '0;
      r_d          <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_busy       <= 1'b0;
      r_glitch_cnt <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_d          <= w_d_nxt;
      r_rise       <= w_rise_nxt;
      r_fall       <= w_fall_nxt;
      r_busy       <= w_busy_nxt;
      r_glitch_cnt <= w_glitch_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next state, counter and transition events
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort     = 1'b0;
    w_commit_hi = 1'b0;
    w_commit_lo = 1'b0;

    unique case (r_state)
      ST_STABLE_LOW: begin
        if (r_sync2) begin
          w_state_nxt = ST_WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end

      ST_WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = ST_STABLE_LOW;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (w_cnt_done) begin
          // Counter is left at its terminal value; it is reloaded on the
          // next WAIT entry, so it never wraps.
          w_state_nxt = ST_STABLE_HIGH;
          w_commit_hi = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end

      ST_STABLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end

      ST_WAIT_LOW: begin
        if (r_sync2) begin
          w_state_nxt = ST_STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_STABLE_LOW;
          w_commit_lo = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_STABLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM process 3: output next values (registered in process 1)
  // ---------------------------------------------------------------------
  always_comb begin
    w_d_nxt      = r_d;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_glitch_nxt = r_glitch_cnt;

    if (w_commit_hi) begin
      w_d_nxt    = 1'b1;
      w_rise_nxt = 1'b1;
    end
    if (w_commit_lo) begin
      w_d_nxt    = 1'b0;
      w_fall_nxt = 1'b1;
    end

    // Saturate: an abort while already at 255 leaves the count alone.
    if (w_abort && (r_glitch_cnt != GC_MAX)) begin
      w_glitch_nxt = r_glitch_cnt + 8'd1;
    end

    w_busy_nxt = (w_state_nxt == ST_WAIT_HIGH) || (w_state_nxt == ST_WAIT_LOW);
  end

  assign bus.d          = r_d;
  assign bus.rise       = r_rise;
  assign bus.fall       = r_fall;
  assign bus.busy       = r_busy;
  assign bus.glitch_cnt = r_glitch_cnt;

endmodule
